// File: rtl/matrix_dispatch_queue_if.sv
// Request/dispatch bus between the sequencing logic and the dispatch queue.
//  master: sequencer side - drives requests and channel done returns
//  slave : dispatch queue - drives ready, starts, coordinates, busy, last_*, err, count
interface matrix_dispatch_queue_if #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned QDEPTH_L = 2
);
  logic                       req_valid;
  logic                       req_ready;
  logic [IDX_W-1:0]           req_index;
  logic [ADDR_W-1:0]          req_x;
  logic [ADDR_W-1:0]          req_y;
  logic [NUM_CH-1:0]          ch_start;
  logic [ADDR_W-1:0]          ch_x;
  logic [ADDR_W-1:0]          ch_y;
  logic [NUM_CH-1:0]          ch_done;
  logic [NUM_CH-1:0]          ch_busy;
  logic [NUM_CH*ADDR_W-1:0]   last_x;
  logic [NUM_CH*ADDR_W-1:0]   last_y;
  logic                       err_index;
  logic [QDEPTH_L:0]          q_count;

  modport master (
    output req_valid, req_index, req_x, req_y, ch_done,
    input  req_ready, ch_start, ch_x, ch_y, ch_busy, last_x, last_y, err_index, q_count
  );

  modport slave (
    input  req_valid, req_index, req_x, req_y, ch_done,
    output req_ready, ch_start, ch_x, ch_y, ch_busy, last_x, last_y, err_index, q_count
  );
endinterface

// File: rtl/matrix_dispatch_queue.sv
// In-order request FIFO that dispatches (x, y) to channel index-1 once that channel
// is idle, tracks per-channel busy via done returns and remembers last coordinates.
//  clk  : clock, rising edge
//  rst  : asynchronous active-high reset
//  bus  : slave side of matrix_dispatch_queue_if (request handshake, channel
//         start/coords/done/busy, last_x/last_y, err_index, q_count)
module matrix_dispatch_queue #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned QDEPTH_L = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_dispatch_queue_if.slave  bus
);

  localparam int unsigned DEPTH  = 1 << QDEPTH_L;
  localparam int unsigned CNT_W  = QDEPTH_L + 1;
  localparam int unsigned LAST_W = NUM_CH * ADDR_W;

  logic [IDX_W-1:0]    r_q_idx [DEPTH];
  logic [ADDR_W-1:0]   r_q_x   [DEPTH];
  logic [ADDR_W-1:0]   r_q_y   [DEPTH];
  logic [QDEPTH_L-1:0] r_wr_ptr;
  logic [QDEPTH_L-1:0] r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_ready;
  logic [NUM_CH-1:0]   r_busy;
  logic [NUM_CH-1:0]   r_start;
  logic [ADDR_W-1:0]   r_ch_x;
  logic [ADDR_W-1:0]   r_ch_y;
  logic [LAST_W-1:0]   r_last_x;
  logic [LAST_W-1:0]   r_last_y;
  logic                r_err;

  logic [IDX_W-1:0]    w_head_idx;
  logic [ADDR_W-1:0]   w_head_x;
  logic [ADDR_W-1:0]   w_head_y;
  logic [NUM_CH-1:0]   w_sel;
  logic                w_empty;
  logic                w_dispatch;
  logic                w_drop;
  logic                w_pop;
  logic                w_push;
  logic [CNT_W-1:0]    w_count_nxt;

  assign w_head_idx = r_q_idx[r_rd_ptr];
  assign w_head_x   = r_q_x[r_rd_ptr];
  assign w_head_y   = r_q_y[r_rd_ptr];
  assign w_empty    = (r_count == '0);

  // One-hot decode of the head index; all-zero means index 0 or beyond NUM_CH.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sel[k] = (w_head_idx == IDX_W'(k + 1));
    end
  end

  // Head blocks everything behind it while its channel is busy.
  assign w_dispatch  = !w_empty && (|w_sel) && !(|(w_sel & r_busy));
  assign w_drop      = !w_empty && !(|w_sel);
  assign w_pop       = w_dispatch || w_drop;
  assign w_push      = bus.req_valid && r_ready;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Queue storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wr_ptr] <= bus.req_index;
      r_q_x[r_wr_ptr]   <= bus.req_x;
      r_q_y[r_wr_ptr]   <= bus.req_y;
    end
  end

  // Pointers, occupancy, channel state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_busy   <= '0;
      r_start  <= '0;
      r_ch_x   <= '0;
      r_ch_y   <= '0;
      r_last_x <= '0;
      r_last_y <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + QDEPTH_L'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + QDEPTH_L'(1);
      r_count <= w_count_nxt;
      // Ready follows next occupancy, so a full queue blocks push even on a pop edge.
      r_ready <= (w_count_nxt != CNT_W'(DEPTH));
      // Done on an idle channel is a no-op; a dispatching channel is never busy.
      r_busy  <= (r_busy & ~bus.ch_done) | (w_dispatch ? w_sel : '0);
      r_start <= w_dispatch ? w_sel : '0;
      r_ch_x  <= w_dispatch ? w_head_x : '0;
      r_ch_y  <= w_dispatch ? w_head_y : '0;
      r_err   <= w_drop;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_dispatch && w_sel[k]) begin
          r_last_x[k*ADDR_W +: ADDR_W] <= w_head_x;
          r_last_y[k*ADDR_W +: ADDR_W] <= w_head_y;
        end
      end
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.ch_start  = r_start;
  assign bus.ch_x      = r_ch_x;
  assign bus.ch_y      = r_ch_y;
  assign bus.ch_busy   = r_busy;
  assign bus.last_x    = r_last_x;
  assign bus.last_y    = r_last_y;
  assign bus.err_index = r_err;
  assign bus.q_count   = r_count;

endmodule
